// File: rtl/mp64_extmem_bridge_pkg.sv
// Shared constants for the 64-bit to 32-bit external bus bridge.
package mp64_extmem_bridge_pkg;

    // Access size codes on the ext_* request port
    localparam logic [1:0] BUS_BYTE  = 2'd0;
    localparam logic [1:0] BUS_HALF  = 2'd1;
    localparam logic [1:0] BUS_WORD  = 2'd2;
    localparam logic [1:0] BUS_DWORD = 2'd3;

    // All four byte lanes live
    localparam logic [3:0]  XB_BE_FULL  = 4'hF;
    // Read data returned with every error ack
    localparam logic [63:0] XB_ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

    // Reads always fetch the whole doubleword; only dword writes need two beats
    function automatic logic is_two_beat(input logic wen, input logic [1:0] size);
        return !wen || (size == BUS_DWORD);
    endfunction

endpackage

// File: rtl/mp64_extmem_bridge_if.sv
// 32-bit external bus (XB). Handshake: a command transfers on a cycle where
// cmd_valid && cmd_ready; once raised, cmd_valid and its payload hold until that
// cycle. rsp_valid is a one-cycle response per accepted beat, with no ready.
interface mp64_extmem_bridge_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;
    logic        abort;

    modport master (
        output cmd_valid, addr, we, be, wdata, abort,
        input  cmd_ready, rsp_valid, rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, addr, we, be, wdata, abort,
        output cmd_ready, rsp_valid, rdata, rsp_err
    );
endinterface

// File: rtl/mp64_xb_beat_gen.sv
// Combinational beat planner: maps a 64-bit request and beat index onto the
// 32-bit bus address, byte enables and lane-positioned write data.
module mp64_xb_beat_gen
    import mp64_extmem_bridge_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [63:0] wdata,
    input  logic        wen,
    input  logic [1:0]  size,
    input  logic        beat,
    output logic [31:0] beat_addr,
    output logic [3:0]  beat_be,
    output logic [31:0] beat_wdata,
    output logic        two_beats
);
    logic [31:0] base;

    assign base = {addr[31:3], 3'b000};

    // Two-beat accesses walk the doubleword; single beats pick the addressed word
    always_comb begin
        two_beats  = is_two_beat(wen, size);
        beat_addr  = base;
        beat_be    = XB_BE_FULL;
        beat_wdata = 32'h0;
        if (two_beats) begin
            beat_addr  = base + (beat ? 32'd4 : 32'd0);
            beat_wdata = wen ? (beat ? wdata[63:32] : wdata[31:0]) : 32'h0;
        end else begin
            beat_addr = base + {29'd0, addr[2], 2'b00};
            case (size)
                BUS_BYTE: begin
                    beat_be    = 4'b0001 << addr[1:0];
                    beat_wdata = {4{wdata[7:0]}};
                end
                BUS_HALF: begin
                    beat_be    = addr[1] ? 4'b1100 : 4'b0011;
                    beat_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    beat_wdata = wdata[31:0];
                end
            endcase
        end
    end
endmodule

// File: rtl/mp64_extmem_bridge.sv
// Bridges one 64-bit ext_* request onto the 32-bit XB bus as one or two beats,
// reassembles read data and guards every beat with a watchdog.
module mp64_extmem_bridge
    import mp64_extmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_req,
    input  logic [63:0] ext_addr,
    input  logic [63:0] ext_wdata,
    input  logic        ext_wen,
    input  logic [1:0]  ext_size,
    output logic [63:0] ext_rdata,
    output logic        ext_ack,
    output logic        ext_err,
    output logic        err_sticky,
    input  logic        err_clr,
    output logic [1:0]  dbg_state,
    mp64_extmem_bridge_if.master xb
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RSP  = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [31:0]      r_addr;
    logic [63:0]      r_wdata;
    logic             r_wen;
    logic [1:0]       r_size;
    logic             beat_idx;
    logic             err_flag;
    logic [63:0]      rbuf;
    logic [CNT_W-1:0] wdog;

    logic [31:0] g_addr;
    logic [63:0] g_wdata;
    logic        g_wen;
    logic [1:0]  g_size;
    logic        g_beat;
    logic [31:0] g_beat_addr;
    logic [3:0]  g_beat_be;
    logic [31:0] g_beat_wdata;
    logic        g_two;

    // In IDLE the first beat is planned straight from the ports so the command
    // register can load on the accepting edge; afterwards only beat 2 is planned.
    assign g_addr  = (state == S_IDLE) ? ext_addr[31:0] : r_addr;
    assign g_wdata = (state == S_IDLE) ? ext_wdata      : r_wdata;
    assign g_wen   = (state == S_IDLE) ? ext_wen        : r_wen;
    assign g_size  = (state == S_IDLE) ? ext_size       : r_size;
    assign g_beat  = (state != S_IDLE);

    assign dbg_state = state;

    mp64_xb_beat_gen u_beat_gen (
        .addr       (g_addr),
        .wdata      (g_wdata),
        .wen        (g_wen),
        .size       (g_size),
        .beat       (g_beat),
        .beat_addr  (g_beat_addr),
        .beat_be    (g_beat_be),
        .beat_wdata (g_beat_wdata),
        .two_beats  (g_two)
    );

    // Request FSM with registered bus and ack outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wen        <= 1'b0;
            r_size       <= '0;
            beat_idx     <= 1'b0;
            err_flag     <= 1'b0;
            rbuf         <= '0;
            wdog         <= '0;
            ext_rdata    <= '0;
            ext_ack      <= 1'b0;
            ext_err      <= 1'b0;
            err_sticky   <= 1'b0;
            xb.cmd_valid <= 1'b0;
            xb.addr      <= '0;
            xb.we        <= 1'b0;
            xb.be        <= '0;
            xb.wdata     <= '0;
            xb.abort     <= 1'b0;
        end else begin
            ext_ack   <= 1'b0;
            ext_err   <= 1'b0;
            ext_rdata <= '0;
            xb.abort  <= 1'b0;
            if (err_clr) begin
                err_sticky <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    // The cycle carrying the ack still sees the old request high
                    if (ext_req && !ext_ack) begin
                        r_addr   <= ext_addr[31:0];
                        r_wdata  <= ext_wdata;
                        r_wen    <= ext_wen;
                        r_size   <= ext_size;
                        beat_idx <= 1'b0;
                        rbuf     <= '0;
                        wdog     <= '0;
                        if (ext_addr[63:32] != 32'h0) begin
                            err_flag <= 1'b1;
                            state    <= S_ACK;
                        end else begin
                            err_flag     <= 1'b0;
                            xb.cmd_valid <= 1'b1;
                            xb.addr      <= g_beat_addr;
                            xb.we        <= ext_wen;
                            xb.be        <= g_beat_be;
                            xb.wdata     <= g_beat_wdata;
                            state        <= S_CMD;
                        end
                    end
                end
                S_CMD: begin
                    if (xb.cmd_ready) begin
                        xb.cmd_valid <= 1'b0;
                        wdog         <= '0;
                        state        <= S_RSP;
                    end else if (wdog == WDOG_LAST) begin
                        xb.cmd_valid <= 1'b0;
                        err_flag     <= 1'b1;
                        state        <= S_ACK;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_RSP: begin
                    if (xb.rsp_valid) begin
                        if (beat_idx) rbuf[63:32] <= xb.rdata;
                        else          rbuf[31:0]  <= xb.rdata;
                        if (xb.rsp_err || beat_idx || !g_two) begin
                            if (xb.rsp_err) err_flag <= 1'b1;
                            state <= S_ACK;
                        end else begin
                            beat_idx     <= 1'b1;
                            wdog         <= '0;
                            xb.cmd_valid <= 1'b1;
                            xb.addr      <= g_beat_addr;
                            xb.be        <= g_beat_be;
                            xb.wdata     <= g_beat_wdata;
                            state        <= S_CMD;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        err_flag <= 1'b1;
                        xb.abort <= 1'b1;
                        state    <= S_ACK;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_ACK: begin
                    ext_ack   <= 1'b1;
                    ext_err   <= err_flag;
                    ext_rdata <= err_flag ? XB_ERR_DATA : (r_wen ? 64'h0 : rbuf);
                    if (err_flag) err_sticky <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mp64_extmem_bridge.sv
// Directed bench for mp64_extmem_bridge: a behavioural XB slave, a request-level
// model feeding expected queues, one per-cycle compare process and literal pins.
module tb_mp64_extmem_bridge;
    import mp64_extmem_bridge_pkg::*;

    logic        clk;
    logic        rst;
    logic        ext_req;
    logic [63:0] ext_addr;
    logic [63:0] ext_wdata;
    logic        ext_wen;
    logic [1:0]  ext_size;
    logic [63:0] ext_rdata;
    logic        ext_ack;
    logic        ext_err;
    logic        err_sticky;
    logic        err_clr;
    logic [1:0]  dbg_state;

    mp64_extmem_bridge_if xb();

    mp64_extmem_bridge #(.TIMEOUT_CYCLES(1024), .CNT_W(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_req    (ext_req),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_wen    (ext_wen),
        .ext_size   (ext_size),
        .ext_rdata  (ext_rdata),
        .ext_ack    (ext_ack),
        .ext_err    (ext_err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr),
        .dbg_state  (dbg_state),
        .xb         (xb)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // scoreboard: {we, be, addr, wdata} per beat, {err, rdata} per ack
    logic [68:0] exp_beat_q[$];
    logic [64:0] exp_ack_q[$];
    logic [31:0] acc_addr_q[$];
    logic [3:0]  acc_be_q[$];
    logic [31:0] acc_wd_q[$];
    int vld_cycles = 0;
    int abort_cnt  = 0;
    int ack_cnt    = 0;

    // XB slave knobs
    logic        slv_ready    = 1'b1;
    int          slv_delay    = 0;
    logic        slv_err_next = 1'b0;
    logic        slv_spurious = 1'b0;
    logic [31:0] slv_q[$];
    logic        slv_pend     = 1'b0;
    int          slv_cnt      = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] log_addr(input int i);
        return (i < acc_addr_q.size()) ? acc_addr_q[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [3:0] log_be(input int i);
        return (i < acc_be_q.size()) ? acc_be_q[i] : 4'hx;
    endfunction
    function automatic logic [31:0] log_wd(input int i);
        return (i < acc_wd_q.size()) ? acc_wd_q[i] : 32'hxxxx_xxxx;
    endfunction

    // Request-level model. mode: 0 ok, 1 address out of range, 2 command timeout,
    // 3 response timeout on beat 1, 4 slave error on beat 1.
    task automatic model_access(input logic [63:0] a, input logic [1:0] sz, input logic w,
                                input logic [63:0] wd, input logic [31:0] lo,
                                input logic [31:0] hi, input int mode);
        logic [68:0] beats[2];
        logic [31:0] base;
        logic [31:0] d;
        logic [3:0]  be;
        int nb, n_issue, n_bytes, off;
        base = {a[31:3], 3'b000};
        if (!w || sz == BUS_DWORD) begin
            nb = 2;
            beats[0] = {w, 4'hF, base,         w ? wd[31:0]  : 32'h0};
            beats[1] = {w, 4'hF, base + 32'd4, w ? wd[63:32] : 32'h0};
        end else begin
            nb = 1;
            n_bytes = (sz == BUS_BYTE) ? 1 : (sz == BUS_HALF) ? 2 : 4;
            off = (sz == BUS_BYTE) ? int'(a[1:0]) : (sz == BUS_HALF) ? int'(a[1]) * 2 : 0;
            be = 4'h0;
            d  = 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + n_bytes) be[i] = 1'b1;
                d[8*i +: 8] = wd[8*(i % n_bytes) +: 8];
            end
            beats[0] = {1'b1, be, base + (a[2] ? 32'd4 : 32'd0), d};
            beats[1] = '0;
        end
        n_issue = (mode == 0) ? nb : (mode == 1 || mode == 2) ? 0 : 1;
        for (int i = 0; i < n_issue; i++) exp_beat_q.push_back(beats[i]);
        if (mode != 0)  exp_ack_q.push_back({1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        else if (w)     exp_ack_q.push_back({1'b0, 64'h0});
        else            exp_ack_q.push_back({1'b0, hi, lo});
    endtask

    // XB slave: drives at the falling edge; a beat accepted on the next rising
    // edge is answered slv_delay cycles later (never when slv_delay < 0)
    initial begin
        xb.cmd_ready = 1'b0;
        xb.rsp_valid = 1'b0;
        xb.rdata     = 32'h0;
        xb.rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            xb.rsp_valid = 1'b0;
            xb.rsp_err   = 1'b0;
            if (rst) begin
                slv_pend = 1'b0;
            end else begin
                if (slv_pend) begin
                    if (slv_cnt == 0) begin
                        xb.rsp_valid = 1'b1;
                        xb.rdata     = (slv_q.size() != 0) ? slv_q.pop_front() : 32'hDEAD_BEEF;
                        xb.rsp_err   = slv_err_next;
                        slv_err_next = 1'b0;
                        slv_pend     = 1'b0;
                    end else begin
                        slv_cnt--;
                    end
                end
                if (slv_spurious) begin
                    xb.rsp_valid = 1'b1;
                    xb.rdata     = 32'h5555_AAAA;
                    slv_spurious = 1'b0;
                end
                xb.cmd_ready = slv_ready;
                if (xb.cmd_valid && xb.cmd_ready && slv_delay >= 0) begin
                    slv_pend = 1'b1;
                    slv_cnt  = slv_delay;
                end
                if (xb.abort) slv_pend = 1'b0;
            end
        end
    end

    // compare process: every cycle, just after the falling edge
    initial begin
        logic [68:0] e;
        logic [64:0] ea;
        logic [68:0] cur;
        logic [68:0] prev;
        logic        prev_wait;
        prev_wait = 1'b0;
        prev      = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_wait = 1'b0;
                continue;
            end
            cur = {xb.we, xb.be, xb.addr, xb.wdata};
            if (xb.cmd_valid) vld_cycles++;
            if (xb.abort) abort_cnt++;
            if (prev_wait && xb.cmd_valid) chk("cmd_stable", cur, prev);
            if (xb.cmd_valid && xb.cmd_ready) begin
                acc_addr_q.push_back(xb.addr);
                acc_be_q.push_back(xb.be);
                acc_wd_q.push_back(xb.wdata);
                if (exp_beat_q.size() == 0) begin
                    chk("unexpected_cmd", exp_beat_q.size(), 1);
                end else begin
                    e = exp_beat_q.pop_front();
                    chk("beat_hdr", cur[68:32], e[68:32]);
                    if (e[68]) chk("beat_wdata", cur[31:0], e[31:0]);
                end
            end
            prev_wait = xb.cmd_valid && !xb.cmd_ready;
            prev      = cur;
            if (ext_ack) begin
                ack_cnt++;
                if (exp_ack_q.size() == 0) begin
                    chk("unexpected_ack", exp_ack_q.size(), 1);
                end else begin
                    ea = exp_ack_q.pop_front();
                    chk("ack_err", ext_err, ea[64]);
                    chk("ack_rdata", ext_rdata, ea[63:0]);
                end
            end else if (ext_err) begin
                chk("err_without_ack", ext_err, 0);
            end
        end
    end

    // driver: one request, held until ack; returns latency and ack-time outputs
    task automatic do_access(input logic [63:0] a, input logic [1:0] sz, input logic w,
                             input logic [63:0] wd, output int lat,
                             output logic [63:0] rd, output logic er);
        acc_addr_q.delete();
        acc_be_q.delete();
        acc_wd_q.delete();
        vld_cycles = 0;
        abort_cnt  = 0;
        @(negedge clk);
        ext_addr  = a;
        ext_size  = sz;
        ext_wen   = w;
        ext_wdata = wd;
        ext_req   = 1'b1;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        while (lat < 3000) begin
            @(negedge clk);
            lat++;
            if (ext_ack) begin
                rd = ext_rdata;
                er = ext_err;
                break;
            end
        end
        ext_req = 1'b0;
        if (lat >= 3000) chk("ack_timeout", lat, 0);
        #2;
        chk("beats_left", exp_beat_q.size(), 0);
        chk("acks_left", exp_ack_q.size(), 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ext"}, {ext_ack, ext_err, err_sticky, ext_rdata, dbg_state}, 0);
        chk({tag, "_xb"}, {xb.cmd_valid, xb.we, xb.be, xb.addr, xb.wdata, xb.abort}, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout actual=1 expected=0");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int          lat;
        logic [63:0] rd;
        logic        er;
        int          acks_before;

        rst       = 1'b1;
        ext_req   = 1'b0;
        ext_addr  = '0;
        ext_wdata = '0;
        ext_wen   = 1'b0;
        ext_size  = BUS_BYTE;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;
        @(negedge clk);

        // T1: dword read, two beats, halves reassembled
        slv_q.push_back(32'h1111_2222);
        slv_q.push_back(32'h3333_4444);
        model_access(64'h1000_0008, BUS_DWORD, 1'b0, 64'h0, 32'h1111_2222, 32'h3333_4444, 0);
        do_access(64'h1000_0008, BUS_DWORD, 1'b0, 64'h0, lat, rd, er);
        chk("t1_latency", lat, 6);
        chk("t1_rdata", rd, 64'h3333_4444_1111_2222);
        chk("t1_err", er, 0);
        chk("t1_beat_count", acc_addr_q.size(), 2);
        chk("t1_beat1_addr", log_addr(0), 32'h1000_0008);
        chk("t1_beat2_addr", log_addr(1), 32'h1000_000C);

        // T2: byte write replicated on all lanes
        model_access(64'h2000_0005, BUS_BYTE, 1'b1, 64'hAB, 32'h0, 32'h0, 0);
        do_access(64'h2000_0005, BUS_BYTE, 1'b1, 64'hAB, lat, rd, er);
        chk("t2_latency", lat, 4);
        chk("t2_beat_count", acc_addr_q.size(), 1);
        chk("t2_addr", log_addr(0), 32'h2000_0004);
        chk("t2_be", log_be(0), 4'b0010);
        chk("t2_wdata", log_wd(0), 32'hABAB_ABAB);
        chk("t2_ack", {er, rd}, 0);

        // T3: half write in the upper lanes, then a word write
        model_access(64'h2000_0002, BUS_HALF, 1'b1, 64'h1234, 32'h0, 32'h0, 0);
        do_access(64'h2000_0002, BUS_HALF, 1'b1, 64'h1234, lat, rd, er);
        chk("t3_half_addr", log_addr(0), 32'h2000_0000);
        chk("t3_half_be", log_be(0), 4'b1100);
        chk("t3_half_wdata", log_wd(0), 32'h1234_1234);
        model_access(64'h2000_0004, BUS_WORD, 1'b1, 64'hCAFE_F00D, 32'h0, 32'h0, 0);
        do_access(64'h2000_0004, BUS_WORD, 1'b1, 64'hCAFE_F00D, lat, rd, er);
        chk("t3_word_addr", log_addr(0), 32'h2000_0004);
        chk("t3_word_be", log_be(0), 4'hF);
        chk("t3_word_latency", lat, 4);

        // odd-address half (addr[0] ignored), dword write, byte-size read
        model_access(64'h2000_0007, BUS_HALF, 1'b1, 64'h00BE, 32'h0, 32'h0, 0);
        do_access(64'h2000_0007, BUS_HALF, 1'b1, 64'h00BE, lat, rd, er);
        chk("half_odd_be", log_be(0), 4'b1100);
        model_access(64'h3000_0010, BUS_DWORD, 1'b1, 64'h8877_6655_4433_2211, 32'h0, 32'h0, 0);
        do_access(64'h3000_0010, BUS_DWORD, 1'b1, 64'h8877_6655_4433_2211, lat, rd, er);
        chk("dw_write_latency", lat, 6);
        chk("dw_write_hi_wdata", log_wd(1), 32'h8877_6655);
        slv_q.push_back(32'h0102_0304);
        slv_q.push_back(32'h0506_0708);
        model_access(64'h7000_0003, BUS_BYTE, 1'b0, 64'h0, 32'h0102_0304, 32'h0506_0708, 0);
        do_access(64'h7000_0003, BUS_BYTE, 1'b0, 64'h0, lat, rd, er);
        chk("byte_read_beats", acc_addr_q.size(), 2);

        // T4: address above 4 GiB errors without touching the bus
        model_access(64'h1_0000_0000, BUS_DWORD, 1'b0, 64'h0, 32'h0, 32'h0, 1);
        do_access(64'h1_0000_0000, BUS_DWORD, 1'b0, 64'h0, lat, rd, er);
        chk("t4_latency", lat, 2);
        chk("t4_err", er, 1);
        chk("t4_rdata", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t4_no_cmd", vld_cycles, 0);
        chk("t4_sticky", err_sticky, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_sticky_cleared", err_sticky, 0);
        // set beats clear when both land on the same edge
        err_clr = 1'b1;
        model_access(64'h2_0000_0000, BUS_WORD, 1'b1, 64'h0, 32'h0, 32'h0, 1);
        do_access(64'h2_0000_0000, BUS_WORD, 1'b1, 64'h0, lat, rd, er);
        chk("sticky_set_wins", err_sticky, 1);
        err_clr = 1'b0;

        // T5a: command never accepted
        slv_ready = 1'b0;
        model_access(64'h4000_0000, BUS_DWORD, 1'b0, 64'h0, 32'h0, 32'h0, 2);
        do_access(64'h4000_0000, BUS_DWORD, 1'b0, 64'h0, lat, rd, er);
        chk("t5a_valid_cycles", vld_cycles, 1024);
        chk("t5a_latency", lat, 1026);
        chk("t5a_err", er, 1);
        chk("t5a_no_abort", abort_cnt, 0);
        slv_ready = 1'b1;

        // T5b: response never arrives
        slv_delay = -1;
        model_access(64'h4000_0040, BUS_DWORD, 1'b0, 64'h0, 32'h0, 32'h0, 3);
        do_access(64'h4000_0040, BUS_DWORD, 1'b0, 64'h0, lat, rd, er);
        chk("t5b_latency", lat, 1027);
        chk("t5b_err", er, 1);
        chk("t5b_rdata", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t5b_abort_pulses", abort_cnt, 1);
        slv_delay = 0;

        // T6a: slave error on beat 1 skips beat 2
        slv_err_next = 1'b1;
        slv_q.push_back(32'h9999_9999);
        model_access(64'h5000_0000, BUS_DWORD, 1'b0, 64'h0, 32'h0, 32'h0, 4);
        do_access(64'h5000_0000, BUS_DWORD, 1'b0, 64'h0, lat, rd, er);
        chk("t6a_latency", lat, 4);
        chk("t6a_beat_count", acc_addr_q.size(), 1);
        chk("t6a_err", er, 1);
        chk("t6a_rdata", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        // response pulse while idle is ignored
        acks_before = ack_cnt;
        @(negedge clk);
        slv_spurious = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_rsp_ignored", ack_cnt, acks_before);

        // T6b: reset while waiting for a response, then a clean access
        slv_delay = 5;
        model_access(64'h6000_0000, BUS_DWORD, 1'b0, 64'h0, 32'h0, 32'h0, 3);
        @(negedge clk);
        ext_addr = 64'h6000_0000;
        ext_size = BUS_DWORD;
        ext_wen  = 1'b0;
        ext_req  = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("t6b_beat1_taken", exp_beat_q.size(), 0);
        rst = 1'b1;
        #1;
        reset_checks("t6b_reset");
        ext_req = 1'b0;
        exp_ack_q.delete();
        exp_beat_q.delete();
        slv_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        slv_delay = 0;
        slv_q.push_back(32'hAAAA_0001);
        slv_q.push_back(32'hBBBB_0002);
        model_access(64'h6000_0018, BUS_DWORD, 1'b0, 64'h0, 32'hAAAA_0001, 32'hBBBB_0002, 0);
        do_access(64'h6000_0018, BUS_DWORD, 1'b0, 64'h0, lat, rd, er);
        chk("t6b_after_latency", lat, 6);
        chk("t6b_after_rdata", rd, 64'hBBBB_0002_AAAA_0001);
        chk("t6b_after_err", er, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
